pts_tx_controller: RTL and testbench

//  Sequences a flexible parallel-to-serial shift register (LSB-first, idle-high, shifts in 1s) for the TX path.

---
 rtl/pts_tx_pkg.sv | 15 +
 rtl/pts_tx_controller_bit_timer.sv | 30 +++
 rtl/pts_tx_controller.sv | 149 ++++++++++++++
 tb/tb_pts_tx_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pts_tx_pkg.sv
// Shared types and constants for the TX serializer controller.
// STUFF stays in the state enum in every build so encodings never shift.
package pts_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  // Length of the run of 1s on the line that forces a stuffed 0.
  localparam int STUFF_RUN = 6;

endpackage

// File: rtl/pts_tx_controller_bit_timer.sv
// Bit-period divider: counts clocks within one serial bit and strobes bit_end_o
// on the last clock of each period. It wraps by itself across bit and word boundaries.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_BIT - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    if (clear_i)                   div_cnt_d = '0;
    else if (div_cnt_q == DIV_MAX) div_cnt_d = '0;
    else                           div_cnt_d = div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

  assign bit_end_o = !clear_i && (div_cnt_q == DIV_MAX);

endmodule

// File: rtl/pts_tx_controller.sv
// TX path sequencer for an LSB-first, idle-high parallel-to-serial shift register.
// Define TX_BIT_STUFF_EN to insert a 0 bit after every run of STUFF_RUN 1s on the line.
module pts_tx_controller
  import pts_tx_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                byte_valid_i,
  input  logic [NUM_BITS-1:0] byte_data_i,
  input  logic                byte_last_i,
  output logic                byte_ready_o,
  output logic                sr_load_o,
  output logic                sr_shift_o,
  output logic [NUM_BITS-1:0] sr_data_o,
  input  logic                sr_serial_i,
  output logic                tx_bit_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                underrun_o
);

  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] BIT_MAX = CW'(NUM_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          last_q, last_d;
  logic          bit_end;
  logic          do_action;
`ifdef TX_BIT_STUFF_EN
  logic [2:0]    ones_cnt_q, ones_cnt_d;
`endif

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  ((state_q == IDLE) || (state_q == DONE)),
    .bit_end_o(bit_end)
  );

  assign sr_data_o = byte_data_i;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

`ifdef TX_BIT_STUFF_EN
  assign tx_bit_o = (state_q == STUFF) ? 1'b0 : sr_serial_i;
`else
  assign tx_bit_o = sr_serial_i;
`endif

  // do_action marks the bit-end action, which stuffing may postpone by one bit period.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    last_d       = last_q;
    byte_ready_o = 1'b0;
    sr_load_o    = 1'b0;
    sr_shift_o   = 1'b0;
    underrun_o   = 1'b0;
    do_action    = 1'b0;
`ifdef TX_BIT_STUFF_EN
    ones_cnt_d   = ones_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        byte_ready_o = byte_valid_i;
        if (byte_valid_i) begin
          sr_load_o = 1'b1;
          last_d    = byte_last_i;
          bit_cnt_d = '0;
          state_d   = SEND;
`ifdef TX_BIT_STUFF_EN
          ones_cnt_d = '0;
`endif
        end
      end
      SEND: begin
        if (bit_end) begin
`ifdef TX_BIT_STUFF_EN
          if (sr_serial_i && (ones_cnt_q == 3'(STUFF_RUN - 1))) begin
            state_d = STUFF;
          end else begin
            ones_cnt_d = sr_serial_i ? ones_cnt_q + 3'd1 : 3'd0;
            do_action  = 1'b1;
          end
`else
          do_action = 1'b1;
`endif
        end
      end
      STUFF: begin
`ifdef TX_BIT_STUFF_EN
        if (bit_end) begin
          ones_cnt_d = '0;
          do_action  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A load at word end takes priority over the shift, giving zero-gap words.
    if (do_action) begin
      if (bit_cnt_q != BIT_MAX) begin
        sr_shift_o = 1'b1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        state_d    = SEND;
      end else if (last_q) begin
        sr_shift_o = 1'b1;
        state_d    = DONE;
      end else if (byte_valid_i) begin
        byte_ready_o = 1'b1;
        sr_load_o    = 1'b1;
        last_d       = byte_last_i;
        bit_cnt_d    = '0;
        state_d      = SEND;
      end else begin
        sr_shift_o = 1'b1;
        underrun_o = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
`ifdef TX_BIT_STUFF_EN
      ones_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
`ifdef TX_BIT_STUFF_EN
      ones_cnt_q <= ones_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pts_tx_controller.sv
// Scoreboard bench for pts_tx_controller driving an idle-high LSB-first shift register model.
// Expectations follow TX_BIT_STUFF_EN when the bench is built with that macro.
module tb_pts_tx_controller;

  localparam int NB  = 8;
  localparam int CPB = 8;
  localparam int EV_HS = 0, EV_DONE = 1, EV_UNDER = 2;
  localparam int SEL_TX = 0, SEL_BUSY = 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          byteValid = 1'b0;
  logic [NB-1:0] byteData = '0;
  logic          byteLast = 1'b0;
  logic          byteReady, srLoad, srShift, srSerial, txBit, busy, done, underrun;
  logic [NB-1:0] srData;
  logic [NB-1:0] srReg;

  typedef struct { int kind; int cycle; } ev_t;
  typedef struct { int sel; int cycle; logic val; } smp_t;
  ev_t  evQ[$];
  smp_t smpQ[$];

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;

  pts_tx_controller #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .byte_valid_i(byteValid),
    .byte_data_i (byteData),
    .byte_last_i (byteLast),
    .byte_ready_o(byteReady),
    .sr_load_o   (srLoad),
    .sr_shift_o  (srShift),
    .sr_data_o   (srData),
    .sr_serial_i (srSerial),
    .tx_bit_o    (txBit),
    .busy_o      (busy),
    .done_o      (done),
    .underrun_o  (underrun)
  );

  // Shift register model: resets to all 1s, load beats shift, shifts 1s in from the top.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       srReg <= '1;
    else if (srLoad)  srReg <= srData;
    else if (srShift) srReg <= {1'b1, srReg[NB-1:1]};
  end
  assign srSerial = srReg[0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string evName(int k);
    case (k)
      EV_HS:   return "handshake";
      EV_DONE: return "done";
      default: return "underrun";
    endcase
  endfunction

  task automatic checkOutput(string name, logic act, logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkEvent(int kind);
    ev_t e;
    testsRun++;
    if (evQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: unexpected at cycle %0d, expected no event", evName(kind), cyc);
    end else begin
      e = evQ.pop_front();
      if (e.kind != kind || e.cycle != cyc) begin
        testsFailed++;
        $display("[TB] FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 evName(kind), cyc, evName(e.kind), e.cycle);
      end
    end
  endtask

  // Monitor: compares DUT events and scheduled line samples against the scoreboard.
  always @(negedge clk) begin
    if (n_rst) begin
      if (byteValid && byteReady) checkEvent(EV_HS);
      if (done)                   checkEvent(EV_DONE);
      if (underrun)               checkEvent(EV_UNDER);
      for (int i = smpQ.size() - 1; i >= 0; i--) begin
        if (smpQ[i].cycle == cyc) begin
          if (smpQ[i].sel == SEL_TX) checkOutput("tx_bit", txBit, smpQ[i].val);
          else                       checkOutput("busy", busy, smpQ[i].val);
          smpQ.delete(i);
        end
      end
    end
  end

  function automatic void pushEv(int kind, int c);
    ev_t e;
    e.kind = kind; e.cycle = c;
    evQ.push_back(e);
  endfunction

  function automatic void pushSmp(int sel, int c, logic v);
    smp_t s;
    s.sel = sel; s.cycle = c; s.val = v;
    smpQ.push_back(s);
  endfunction

  // Mid-bit samples of a word whose handshake is sampled at cycle h.
  function automatic void pushBits(int h, logic [NB-1:0] d, int n);
    for (int k = 0; k < n; k++) pushSmp(SEL_TX, h + 5 + CPB * k, d[k]);
  endfunction

  task automatic stepTo(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(logic v, logic [NB-1:0] d, logic l);
    byteValid = v;
    byteData  = d;
    byteLast  = l;
  endtask

  task automatic waitHandshake(string name);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (byteValid && byteReady) break;
      n++;
    end
    if (n >= 200) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: no handshake within 200 cycles, got none, expected one", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendA5(int start);
    stepTo(start);
    pushEv(EV_HS, start);
    pushBits(start, 8'hA5, 8);
    pushEv(EV_DONE, start + 65);
    pushSmp(SEL_BUSY, start + 64, 1'b1);
    pushSmp(SEL_BUSY, start + 66, 1'b0);
    pushSmp(SEL_TX, start + 66, 1'b1);
    pushSmp(SEL_TX, start + 70, 1'b1);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    waitHandshake("a5");
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepTo(start + 75);
  endtask

  initial begin
    int c;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst byte_ready", byteReady, 1'b0);
    checkOutput("rst sr_load", srLoad, 1'b0);
    checkOutput("rst sr_shift", srShift, 1'b0);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst done", done, 1'b0);
    checkOutput("rst underrun", underrun, 1'b0);
    checkOutput("rst tx_bit", txBit, 1'b1);
    n_rst = 1'b1;
    stepTo(cyc + 2);

    // Single last word 0xA5.
    sendA5(cyc + 1);

    // Back-to-back 0x01 then 0x80 with valid held.
    c = cyc + 1;
    stepTo(c);
    pushEv(EV_HS, c);
    pushBits(c, 8'h01, 8);
    pushEv(EV_HS, c + 64);
    pushBits(c + 64, 8'h80, 8);
    pushEv(EV_DONE, c + 129);
    pushSmp(SEL_BUSY, c + 64, 1'b1);
    pushSmp(SEL_BUSY, c + 130, 1'b0);
    pushSmp(SEL_TX, c + 131, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b0);
    waitHandshake("b2b first");
    applyStimulus(1'b1, 8'h80, 1'b1);
    waitHandshake("b2b second");
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepTo(c + 136);

    // Non-last word 0x3C followed by starvation.
    c = cyc + 1;
    stepTo(c);
    pushEv(EV_HS, c);
    pushBits(c, 8'h3C, 8);
    pushEv(EV_UNDER, c + 64);
    pushSmp(SEL_BUSY, c + 64, 1'b1);
    pushSmp(SEL_BUSY, c + 65, 1'b0);
    pushSmp(SEL_TX, c + 66, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    waitHandshake("underrun");
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepTo(c + 75);

    // Word 0xFF, last: a stuffed 0 after six 1s when stuffing is built in.
    c = cyc + 1;
    stepTo(c);
    pushEv(EV_HS, c);
`ifdef TX_BIT_STUFF_EN
    pushBits(c, 8'h3F, 6);
    pushSmp(SEL_TX, c + 5 + CPB * 6, 1'b0);
    pushSmp(SEL_TX, c + 5 + CPB * 7, 1'b1);
    pushSmp(SEL_TX, c + 5 + CPB * 8, 1'b1);
    pushEv(EV_DONE, c + 73);
    pushSmp(SEL_BUSY, c + 74, 1'b0);
`else
    pushBits(c, 8'hFF, 8);
    pushEv(EV_DONE, c + 65);
    pushSmp(SEL_BUSY, c + 66, 1'b0);
`endif
    applyStimulus(1'b1, 8'hFF, 1'b1);
    waitHandshake("ff");
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepTo(c + 85);

    // Reset in the middle of bit 3 of 0x0F, then a clean restart.
    c = cyc + 1;
    stepTo(c);
    pushEv(EV_HS, c);
    pushBits(c, 8'h0F, 3);
    applyStimulus(1'b1, 8'h0F, 1'b1);
    waitHandshake("reset word");
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepTo(c + 28);
    n_rst = 1'b0;
    #1;
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst done", done, 1'b0);
    checkOutput("midrst underrun", underrun, 1'b0);
    checkOutput("midrst sr_load", srLoad, 1'b0);
    checkOutput("midrst sr_shift", srShift, 1'b0);
    checkOutput("midrst byte_ready", byteReady, 1'b0);
    checkOutput("midrst tx_bit", txBit, 1'b1);
    stepTo(cyc + 2);
    n_rst = 1'b1;
    stepTo(cyc + 2);
    sendA5(cyc + 1);

    stepTo(cyc + 10);
    foreach (evQ[i]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL missing %s: got none, expected at cycle %0d", evName(evQ[i].kind), evQ[i].cycle);
    end
    foreach (smpQ[i]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unchecked sample sel %0d: got none, expected %b at cycle %0d",
               smpQ[i].sel, smpQ[i].val, smpQ[i].cycle);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
